npu_cube_product_code_gen: RTL

NPU_CUBE_PRODUCT_CODE_GEN -- requirements
Module: npu_cube_product_code_gen

---
 rtl/npu_cube_pkg.sv | 46 ++++
 rtl/npu_cube_product_code_gen_if.sv | 29 ++
 rtl/npu_cube_booth_lane.sv | 31 +++
 rtl/npu_cube_product_code_gen.sv | 129 ++++++++++++
 4 files changed

// File: rtl/npu_cube_pkg.sv
// Shared widths, Booth code constants and the radix-4 Booth encoder used by
// the cube partial-product generator.
package npu_cube_pkg;

  localparam int NPU_CUBE_MAC_PP  = 11;
  localparam int NPU_CUBE_MAC_NUM = 8;
  localparam int DWA              = 8;
  localparam int DWB              = 8;
  localparam int DWB_CODE         = 12;
  localparam int DWB_PER_CODE     = 3;
  localparam int NUM_DIGITS       = DWB_CODE / DWB_PER_CODE;

  typedef logic [DWB_PER_CODE-1:0] code_t;
  typedef code_t [NUM_DIGITS-1:0]  codes_t;

  // [2] = negate, [1:0] = magnitude; 100 and 111 are never produced
  localparam code_t CODE_ZERO = 3'b000;
  localparam code_t CODE_P1   = 3'b001;
  localparam code_t CODE_P2   = 3'b010;
  localparam code_t CODE_M1   = 3'b101;
  localparam code_t CODE_M2   = 3'b110;

  localparam logic [1:0] LAST_DIGIT = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  function automatic codes_t booth_encode(input logic [DWB-1:0] b);
    logic [DWB:0] ext;
    code_t        trip;
    codes_t       c;
    ext = {b, 1'b0};
    c   = {NUM_DIGITS{CODE_ZERO}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      trip = ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: c[i] = CODE_P1;
        3'b011:         c[i] = CODE_P2;
        3'b100:         c[i] = CODE_M2;
        3'b101, 3'b110: c[i] = CODE_M1;
        default:        c[i] = CODE_ZERO;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/npu_cube_product_code_gen_if.sv
// Operand-in / partial-product-out handshake bundle for the cube Booth generator.
interface npu_cube_product_code_gen_if #(
  parameter int NPU_CUBE_MAC_PP  = npu_cube_pkg::NPU_CUBE_MAC_PP,
  parameter int NPU_CUBE_MAC_NUM = npu_cube_pkg::NPU_CUBE_MAC_NUM,
  parameter int DWA              = npu_cube_pkg::DWA,
  parameter int DWB              = npu_cube_pkg::DWB,
  parameter int DWB_PER_CODE     = npu_cube_pkg::DWB_PER_CODE
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [DWA*NPU_CUBE_MAC_NUM-1:0]           a_vec;
  logic [DWB-1:0]                            b_val;
  logic                                      pp_valid;
  logic                                      pp_ready;
  logic [NPU_CUBE_MAC_PP*NPU_CUBE_MAC_NUM-1:0] linedata;
  logic [DWB_PER_CODE-1:0]                   pp_code;
  logic [1:0]                                pp_digit;
  logic                                      pp_last;

  modport master (
    output in_valid, a_vec, b_val, pp_ready,
    input  in_ready, pp_valid, linedata, pp_code, pp_digit, pp_last
  );

  modport slave (
    input  in_valid, a_vec, b_val, pp_ready,
    output in_ready, pp_valid, linedata, pp_code, pp_digit, pp_last
  );
endinterface

// File: rtl/npu_cube_booth_lane.sv
// One activation lane: scales a signed activation by a Booth code (0, +-1, +-2)
// and sign-extends to the partial-product width.
module npu_cube_booth_lane
  import npu_cube_pkg::*;
#(
  parameter int A_W  = 8,
  parameter int PP_W = 11
) (
  input  logic [A_W-1:0]  a_i,
  input  code_t           code_i,
  output logic [PP_W-1:0] pp_o
);

  logic [PP_W-1:0] ax_s;
  logic [PP_W-1:0] mag_s;

  always_comb begin
    ax_s = {{(PP_W-A_W){a_i[A_W-1]}}, a_i};
    case (code_i[1:0])
      2'b01:   mag_s = ax_s;
      2'b10:   mag_s = {ax_s[PP_W-2:0], 1'b0};
      default: mag_s = {PP_W{1'b0}};
    endcase
    if (code_i[2]) begin
      pp_o = -mag_s;
    end else begin
      pp_o = mag_s;
    end
  end

endmodule

// File: rtl/npu_cube_product_code_gen.sv
// Latches an activation vector and a Booth-encoded weight, then streams four
// registered partial-product lines (one per Booth digit) to the adder tree.
module npu_cube_product_code_gen #(
  parameter int NPU_CUBE_MAC_PP  = npu_cube_pkg::NPU_CUBE_MAC_PP,
  parameter int NPU_CUBE_MAC_NUM = npu_cube_pkg::NPU_CUBE_MAC_NUM,
  parameter int DWA              = npu_cube_pkg::DWA,
  parameter int DWB              = npu_cube_pkg::DWB
) (
  input logic                        clk,
  input logic                        rst,
  npu_cube_product_code_gen_if.slave bus
);

  localparam int AW = DWA * NPU_CUBE_MAC_NUM;
  localparam int LW = NPU_CUBE_MAC_PP * NPU_CUBE_MAC_NUM;

  npu_cube_pkg::state_e state_q, state_d;
  logic [AW-1:0]        a_q, a_d;
  npu_cube_pkg::codes_t codes_q, codes_d, codes_new_s;
  npu_cube_pkg::code_t  code_q, code_d, lane_code_s;
  logic [1:0]           digit_q, digit_d, digit_next_s;
  logic [LW-1:0]        line_q, line_d, lane_pp_s;
  logic                 valid_q, valid_d, last_q, last_d;
  logic [AW-1:0]        lane_a_s;
  logic [DWB-1:0]       b_s;
  logic                 in_ready_s, accept_s, advance_s, done_s;

  assign b_s = bus.b_val;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= npu_cube_pkg::S_IDLE;
      a_q     <= {AW{1'b0}};
      codes_q <= {npu_cube_pkg::NUM_DIGITS{npu_cube_pkg::CODE_ZERO}};
      code_q  <= npu_cube_pkg::CODE_ZERO;
      digit_q <= 2'd0;
      line_q  <= {LW{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      codes_q <= codes_d;
      code_q  <= code_d;
      digit_q <= digit_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Handshake decode and lane operand select (fresh operands on accept)
  always_comb begin
    digit_next_s = digit_q + 2'd1;
    codes_new_s  = npu_cube_pkg::booth_encode(b_s);
    if (state_q == npu_cube_pkg::S_RUN) begin
      advance_s = bus.pp_ready && (digit_q != npu_cube_pkg::LAST_DIGIT);
      done_s    = bus.pp_ready && (digit_q == npu_cube_pkg::LAST_DIGIT);
    end else begin
      advance_s = 1'b0;
      done_s    = 1'b0;
    end
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = (state_q == npu_cube_pkg::S_IDLE) || done_s;
    end
    accept_s = bus.in_valid && in_ready_s;
    if (accept_s) begin
      lane_a_s    = bus.a_vec;
      lane_code_s = codes_new_s[0];
    end else begin
      lane_a_s    = a_q;
      lane_code_s = codes_q[digit_next_s];
    end
  end

  // Next-state and next-line computation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    codes_d = codes_q;
    code_d  = code_q;
    digit_d = digit_q;
    line_d  = line_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept_s) begin
      state_d = npu_cube_pkg::S_RUN;
      a_d     = bus.a_vec;
      codes_d = codes_new_s;
      code_d  = lane_code_s;
      digit_d = 2'd0;
      line_d  = lane_pp_s;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (advance_s) begin
      code_d  = lane_code_s;
      digit_d = digit_next_s;
      line_d  = lane_pp_s;
      last_d  = (digit_next_s == npu_cube_pkg::LAST_DIGIT);
    end else if (done_s) begin
      state_d = npu_cube_pkg::S_IDLE;
      valid_d = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  for (genvar k = 0; k < NPU_CUBE_MAC_NUM; k++) begin : g_lane
    npu_cube_booth_lane #(
      .A_W  (DWA),
      .PP_W (NPU_CUBE_MAC_PP)
    ) u_lane (
      .a_i    (lane_a_s[DWA*k +: DWA]),
      .code_i (lane_code_s),
      .pp_o   (lane_pp_s[NPU_CUBE_MAC_PP*k +: NPU_CUBE_MAC_PP])
    );
  end

  assign bus.in_ready = in_ready_s;
  assign bus.pp_valid = valid_q;
  assign bus.linedata = line_q;
  assign bus.pp_code  = code_q;
  assign bus.pp_digit = digit_q;
  assign bus.pp_last  = last_q;

endmodule
